// File: rtl/bram_tile_pkg.sv
// Shared definitions for the tile BRAM address generators (fetch and writeback side):
// the tile FSM state encoding plus helpers for offset sizing and word address computation.
package bram_tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } tile_state_e;

  // Width of a counter that indexes the words of one tile; never narrower than one bit.
  function automatic int offset_width(input int words_per_tile);
    return (words_per_tile > 1) ? $clog2(words_per_tile) : 1;
  endfunction

  // The low bits of this 32-bit result match a calculation done at exactly
  // ADDR_WIDTH+TILE_PTR_WIDTH bits, so callers simply truncate to ADDR_WIDTH.
  function automatic logic [31:0] tile_addr(input logic [31:0] tile_ptr,
                                            input logic [31:0] words_per_tile,
                                            input logic [31:0] offset);
    return (tile_ptr * words_per_tile) + offset;
  endfunction

endpackage

// File: rtl/tile_addr_ptr.sv
// Tile pointer with immediate/deferred clear and wrap handling plus word address output.
// Optional sticky wrap error output when WB_WRAP_ERR_EN is defined.
module tile_addr_ptr
  import bram_tile_pkg::*;
#(
  parameter int NUM_WRITES_PER_TILE = 2,
  parameter int ADDR_WIDTH          = 11,
  parameter int MAX_TILES           = 384,
  parameter int TILE_PTR_WIDTH      = 9,
  parameter int OFFSET_WIDTH        = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    idle_i,
  input  logic                    active_i,
  input  logic                    advance_i,
  input  logic [OFFSET_WIDTH-1:0] offset_i,
  output logic [ADDR_WIDTH-1:0]   addr_o
`ifdef WB_WRAP_ERR_EN
  ,
  output logic                    wrap_err_o
`endif
);

  logic [TILE_PTR_WIDTH-1:0] tile_ptr_q, tile_ptr_d;
  logic                      pending_q, pending_d;
`ifdef WB_WRAP_ERR_EN
  logic                      wrap_err_q, wrap_err_d;
`endif

  // A clear seen mid-tile is only remembered; the pointer must stay put until the tile completes.
  always_comb begin
    tile_ptr_d = tile_ptr_q;
    pending_d  = pending_q;
`ifdef WB_WRAP_ERR_EN
    wrap_err_d = wrap_err_q;
`endif
    if (idle_i && clear_i) begin
      tile_ptr_d = '0;
      pending_d  = 1'b0;
`ifdef WB_WRAP_ERR_EN
      wrap_err_d = 1'b0;
`endif
    end else if (active_i && clear_i) begin
      pending_d = 1'b1;
    end else if (advance_i) begin
      if (clear_i || pending_q) begin
        tile_ptr_d = '0;
        pending_d  = 1'b0;
`ifdef WB_WRAP_ERR_EN
        wrap_err_d = 1'b0;
`endif
      end else if (tile_ptr_q == TILE_PTR_WIDTH'(MAX_TILES - 1)) begin
        tile_ptr_d = '0;
`ifdef WB_WRAP_ERR_EN
        wrap_err_d = 1'b1;
`endif
      end else begin
        tile_ptr_d = tile_ptr_q + TILE_PTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_ptr_q <= '0;
      pending_q  <= 1'b0;
`ifdef WB_WRAP_ERR_EN
      wrap_err_q <= 1'b0;
`endif
    end else begin
      tile_ptr_q <= tile_ptr_d;
      pending_q  <= pending_d;
`ifdef WB_WRAP_ERR_EN
      wrap_err_q <= wrap_err_d;
`endif
    end
  end

  assign addr_o = ADDR_WIDTH'(tile_addr(32'(tile_ptr_q), 32'(NUM_WRITES_PER_TILE), 32'(offset_i)));

`ifdef WB_WRAP_ERR_EN
  assign wrap_err_o = wrap_err_q;
`endif

endmodule

// File: rtl/writeback_logic_gen.sv
// Writes one result tile (NUM_WRITES_PER_TILE words from a valid/ready stream) to a BRAM port.
// Define WB_WRAP_ERR_EN to add the sticky wrap_err output.
module writeback_logic_gen
  import bram_tile_pkg::*;
#(
  parameter int NUM_WRITES_PER_TILE = 2,
  parameter int ADDR_WIDTH          = 11,
  parameter int DATA_WIDTH          = 16,
  parameter int MAX_TILES           = 384,
  parameter int TILE_PTR_WIDTH      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_write,
  input  logic                  reset_addr_counter,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  write_done,
  output logic                  busy
`ifdef WB_WRAP_ERR_EN
  ,
  output logic                  wrap_err
`endif
);

  localparam int OffsetWidth = offset_width(NUM_WRITES_PER_TILE);

  tile_state_e            state_q, state_d;
  logic [OffsetWidth-1:0] offset_q, offset_d;
  logic                   bram_en_q, bram_en_d;
  logic [ADDR_WIDTH-1:0]  bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0]  bram_wdata_q, bram_wdata_d;
  logic [ADDR_WIDTH-1:0]  word_addr;
  logic                   beat;
  logic                   last_word;

  assign in_ready   = (state_q == ST_WRITING);
  assign beat       = in_valid && in_ready;
  assign last_word  = (offset_q == OffsetWidth'(NUM_WRITES_PER_TILE - 1));
  assign busy       = (state_q != ST_IDLE);
  assign write_done = (state_q == ST_DONE);

  tile_addr_ptr #(
    .NUM_WRITES_PER_TILE(NUM_WRITES_PER_TILE),
    .ADDR_WIDTH         (ADDR_WIDTH),
    .MAX_TILES          (MAX_TILES),
    .TILE_PTR_WIDTH     (TILE_PTR_WIDTH),
    .OFFSET_WIDTH       (OffsetWidth)
  ) u_tile_addr_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (reset_addr_counter),
    .idle_i    (state_q == ST_IDLE),
    .active_i  ((state_q == ST_WRITING) || (state_q == ST_DRAIN)),
    .advance_i (state_q == ST_DONE),
    .offset_i  (offset_q),
    .addr_o    (word_addr)
`ifdef WB_WRAP_ERR_EN
    ,
    .wrap_err_o(wrap_err)
`endif
  );

  // Address and data hold between beats; only the enable drops when no word is accepted.
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    bram_en_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_write) begin
          state_d = ST_WRITING;
        end
      end
      ST_WRITING: begin
        if (beat) begin
          bram_en_d    = 1'b1;
          bram_addr_d  = word_addr;
          bram_wdata_d = in_data;
          offset_d     = offset_q + OffsetWidth'(1);
          if (last_word) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        offset_d = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      offset_q     <= '0;
      bram_en_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      bram_en_q    <= bram_en_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign bram_en    = bram_en_q;
  assign bram_we    = bram_en_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_writeback_logic_gen.sv
// Randomized self-checking bench for writeback_logic_gen against a tile-level reference model.
// Checks wrap_err as well when WB_WRAP_ERR_EN is defined.
module tb_writeback_logic_gen;

  localparam int N    = 3;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int MAXT = 7;
  localparam int TW   = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_write = 1'b0;
  logic          reset_addr_counter = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          bram_we;
  logic [DW-1:0] bram_wdata;
  logic          write_done;
  logic          busy;
`ifdef WB_WRAP_ERR_EN
  logic          wrap_err;
`endif

  writeback_logic_gen #(
    .NUM_WRITES_PER_TILE(N),
    .ADDR_WIDTH         (AW),
    .DATA_WIDTH         (DW),
    .MAX_TILES          (MAXT),
    .TILE_PTR_WIDTH     (TW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_write       (start_write),
    .reset_addr_counter(reset_addr_counter),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .bram_addr         (bram_addr),
    .bram_en           (bram_en),
    .bram_we           (bram_we),
    .bram_wdata        (bram_wdata),
    .write_done        (write_done),
    .busy              (busy)
`ifdef WB_WRAP_ERR_EN
    ,
    .wrap_err          (wrap_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which tile the next tile lands in, and whether a clear is owed.
  int            tile = 0;
  bit            clearNext = 1'b0;
  bit            expWrap = 1'b0;
  bit            expEn, expDone, expBusy, expReady;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [AW-1:0] wordAddr(input int t, input int k);
    return AW'((t * N + k) % (1 << AW));
  endfunction

  task automatic applyStimulus(input bit sw, input bit rac, input bit valid, input logic [DW-1:0] data);
    start_write        = sw;
    reset_addr_counter = rac;
    in_valid           = valid;
    in_data            = data;
  endtask

  task automatic setExpect(input bit en, input bit done, input bit bsy, input bit rdy);
    expEn    = en;
    expDone  = done;
    expBusy  = bsy;
    expReady = rdy;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    checkOutput("bram_en", bram_en, expEn);
    checkOutput("bram_we", bram_we, expEn);
    checkOutput("write_done", write_done, expDone);
    checkOutput("busy", busy, expBusy);
    checkOutput("in_ready", in_ready, expReady);
    if (expEn) begin
      checkOutput("bram_addr", bram_addr, expAddr);
      checkOutput("bram_wdata", bram_wdata, expData);
    end
`ifdef WB_WRAP_ERR_EN
    checkOutput("wrap_err", wrap_err, expWrap);
`endif
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_bram_en", bram_en, 0);
    checkOutput("rst_bram_we", bram_we, 0);
    checkOutput("rst_bram_addr", bram_addr, 0);
    checkOutput("rst_bram_wdata", bram_wdata, 0);
    checkOutput("rst_write_done", write_done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
`ifdef WB_WRAP_ERR_EN
    checkOutput("rst_wrap_err", wrap_err, 0);
`endif
  endtask

  function automatic bit junkBit(input bit junk);
    return junk ? bit'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // One complete tile from the IDLE start cycle back to IDLE; clears may be placed at start, mid-tile or in DONE.
  task automatic runTile(input int gapMin, input int gapMax, input bit racStart, input bit racMid, input bit junk);
    int            racAt;
    int            gaps;
    bit            racDone;
    logic [DW-1:0] d;
    racAt = racMid ? int'($urandom_range(0, N)) : -1;

    applyStimulus(1'b1, racStart, junkBit(junk), DW'($urandom));
    if (racStart) begin
      tile    = 0;
      expWrap = 1'b0;
    end
    setExpect(1'b0, 1'b0, 1'b1, 1'b1);
    sampleCycle();

    for (int k = 0; k < N; k++) begin
      gaps = int'($urandom_range(gapMin, gapMax));
      for (int g = 0; g < gaps; g++) begin
        applyStimulus(junkBit(junk), 1'b0, 1'b0, DW'($urandom));
        setExpect(1'b0, 1'b0, 1'b1, 1'b1);
        sampleCycle();
      end
      d = DW'($urandom);
      applyStimulus(junkBit(junk), (k == racAt), 1'b1, d);
      if (k == racAt) clearNext = 1'b1;
      expAddr = wordAddr(tile, k);
      expData = d;
      setExpect(1'b1, 1'b0, 1'b1, (k != N - 1));
      sampleCycle();
    end

    applyStimulus(junkBit(junk), (racAt == N), junkBit(junk), DW'($urandom));
    if (racAt == N) clearNext = 1'b1;
    setExpect(1'b0, 1'b1, 1'b1, 1'b0);
    sampleCycle();

    racDone = junk && ($urandom_range(0, 3) == 0);
    applyStimulus(junkBit(junk), racDone, junkBit(junk), DW'($urandom));
    if (clearNext || racDone) begin
      tile    = 0;
      expWrap = 1'b0;
    end else if (tile == MAXT - 1) begin
      tile    = 0;
      expWrap = 1'b1;
    end else begin
      tile++;
    end
    clearNext = 1'b0;
    setExpect(1'b0, 1'b0, 1'b0, 1'b0);
    sampleCycle();
  endtask

  task automatic idleCycle(input bit rac, input bit junk);
    applyStimulus(1'b0, rac, junkBit(junk), DW'($urandom));
    if (rac) begin
      tile    = 0;
      expWrap = 1'b0;
    end
    setExpect(1'b0, 1'b0, 1'b0, 1'b0);
    sampleCycle();
  endtask

  // Abort partway through a tile; afterwards everything starts again from tile 0.
  task automatic resetMidTile();
    logic [DW-1:0] d;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    setExpect(1'b0, 1'b0, 1'b1, 1'b1);
    sampleCycle();
    d = DW'($urandom);
    applyStimulus(1'b0, 1'b0, 1'b1, d);
    expAddr = wordAddr(tile, 0);
    expData = d;
    setExpect(1'b1, 1'b0, 1'b1, 1'b1);
    sampleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom));
    #2 rst_n = 1'b0;
    #1 checkResetOutputs();
    tile      = 0;
    clearNext = 1'b0;
    expWrap   = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    setExpect(1'b0, 1'b0, 1'b0, 1'b0);
    sampleCycle();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    #12 checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;
    setExpect(1'b0, 1'b0, 1'b0, 1'b0);
    sampleCycle();

    // Back-to-back words, then consecutive tiles, then a tile with forced gaps.
    runTile(0, 0, 1'b0, 1'b0, 1'b0);
    runTile(0, 0, 1'b0, 1'b0, 1'b0);
    runTile(2, 2, 1'b0, 1'b0, 1'b0);
    runTile(0, 1, 1'b0, 1'b0, 1'b0);
    runTile(0, 1, 1'b0, 1'b0, 1'b0);
    // Tile 5 with a mid-tile clear: stays at its own address, the next tile goes to 0.
    runTile(0, 1, 1'b0, 1'b1, 1'b0);

    // Walk through the wrap point, then clear from IDLE.
    for (int i = 0; i < MAXT + 1; i++) runTile(0, 0, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b1, 1'b0);
    runTile(0, 0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycle(bit'($urandom_range(0, 1)), 1'b1);
      runTile(0, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), 1'b1);
    end

    runTile(0, 0, 1'b0, 1'b0, 1'b0);
    resetMidTile();
    runTile(0, 0, 1'b0, 1'b0, 1'b0);
    runTile(0, 1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_logic_gen.md
Name: writeback_logic_gen

Overview:
- Write-side counterpart of the tile fetch address generator.
- Accepts one result tile as NUM_WRITES_PER_TILE words over a valid/ready stream and writes them to a BRAM write port.
- Word address = tile_ptr*NUM_WRITES_PER_TILE + offset; tile_ptr advances after each completed tile.
- Sits between the accelerator output datapath and the result buffer BRAM, controlled by the arbiter.

Parameters:
- NUM_WRITES_PER_TILE, 2, BRAM words per tile (>=1)
- ADDR_WIDTH, 11, BRAM address width
- DATA_WIDTH, 16, BRAM word width
- MAX_TILES, 384, tile pointer wraps to 0 after MAX_TILES-1
- TILE_PTR_WIDTH, 9, tile pointer width (>= clog2(MAX_TILES))

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_write  in  1  pulse: begin accepting the next tile
- reset_addr_counter  in  1  pulse: return tile_ptr to 0
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word (combinational from state)
- in_data  in  DATA_WIDTH  input word
- bram_addr  out  ADDR_WIDTH  write address (registered)
- bram_en  out  1  BRAM port enable (registered)
- bram_we  out  1  BRAM write enable (registered, equals bram_en)
- bram_wdata  out  DATA_WIDTH  write data (registered)
- write_done  out  1  one-cycle pulse, tile fully written
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; tile_ptr 0; offset 0; reset-pending flag 0. Reset is honoured mid-tile; partial tile data is discarded.
- States and transitions:
  - IDLE: start_write -> WRITING. start_write in any other state is ignored.
  - WRITING: in_ready=1.
    - Beat = in_valid && in_ready.
    - Each beat registers bram_en=bram_we=1, bram_addr=(tile_ptr*N+offset) truncated to ADDR_WIDTH, bram_wdata=in_data, and increments offset.
    - No beat: bram_en/bram_we=0 next cycle; offset holds.
    - Beat with offset==N-1 -> DRAIN.
  - DRAIN: in_ready=0; the last word is on the BRAM port this cycle -> DONE.
  - DONE: write_done=1; offset<=0; tile_ptr update (below) -> IDLE.
- Latency:
  - Beat-to-BRAM write is 1 cycle.
  - write_done is 1 cycle after the final write.
  - Minimum tile time from start_write = N+3 cycles.
- tile_ptr update in DONE:
  - If reset_addr_counter or pending flag: tile_ptr<=0, clear pending.
  - Else if tile_ptr==MAX_TILES-1: tile_ptr<=0 (wrap).
  - Else tile_ptr+1.
- reset_addr_counter in IDLE: tile_ptr<=0 at the next edge, including when coincident with start_write; that tile goes to tile 0.
- reset_addr_counter in WRITING/DRAIN: sets the pending flag. The current tile keeps its address; the reset is applied in DONE.
- Address arithmetic is done at ADDR_WIDTH+TILE_PTR_WIDTH bits, then truncated.

Optional Feature:
- Macro: WB_WRAP_ERR_EN.
- Defined: adds output wrap_err (1 bit, reset 0).
  - Set sticky when tile_ptr wraps MAX_TILES-1 -> 0 by increment.
  - Cleared by reset_addr_counter, applied immediately or when pending.
- Undefined: no port, silent wrap.

Decomposition:
- Package bram_tile_pkg: state encodings (IDLE, WRITING, DRAIN, DONE) and a tile_addr calculation function, shared with the fetch generator.
- One natural sub-module, tile_addr_ptr: tile pointer with reset/pending/wrap logic plus address computation, reusable by the read side.

Test Plan (N=2, ADDR_WIDTH=11, DATA_WIDTH=16 unless stated):
- Reset release, start_write, in_valid held with 0x00A0, 0x00A1 -> writes addr0=0x00A0, addr1=0x00A1 on consecutive cycles; write_done exactly 1 cycle after the second write; next tile goes to addr 2,3.
- in_valid low for 2 cycles between beats -> no bram_en in the gap; offset holds; second word lands at addr+1; write_done timing relative to the last write unchanged.
- reset_addr_counter pulsed during WRITING of tile 5 -> tile 5 written to 10,11; next tile written to 0,1.
- MAX_TILES=4, five tiles -> fifth tile at addr 0,1; with WB_WRAP_ERR_EN, wrap_err=1 after the fourth write_done, cleared by reset_addr_counter.
- start_write pulsed during WRITING and DRAIN -> ignored; exactly one write_done per tile.
- rst_n asserted after the first beat -> all outputs 0 within reset; after release, a new tile starts at addr 0.
